// File: rtl/alu_wb_pkg.sv
// Purpose: shared types and constants for the ALU writeback stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_wb_pkg;

   localparam int VEC_W     = 512;
   localparam int LANES     = 16;
   localparam int REG_IDX_W = 2;
   localparam logic [1:0] CC_OVF = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2
   } wb_state_t;

endpackage

// File: rtl/lane_ovf_reduce.sv
// Purpose: OR-reduce per-lane condition codes into one "any lane overflowed" bit.
// Latency: combinational.
// Backpressure: none.
// Ports: cc (2 bits per lane) in, any_ovf out.
module lane_ovf_reduce
   import alu_wb_pkg::*;
(
   input  logic [2*LANES-1:0] cc,
   output logic               any_ovf
);

   always_comb begin
      any_ovf = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (cc[2*i +: 2] == CC_OVF) begin
            any_ovf = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_writeback.sv
// Purpose: capture a 1024-bit ALU result and write it to the vector register file
//          as one (low) or two (low then high) 512-bit writes; track cc flags and op count.
// Latency: capture at edge N, low write presented from N+1, high write from N+2 (no stall).
// Backpressure: in_ready only in IDLE; wr_stall freezes the current write in place.
// Ports: in_valid/in_ready/result/cc/rd_lo/rd_hi/wr_hi (ALU side),
//        wr_stall/wr_en/wr_addr/wr_data (register file side),
//        cc_q/ovf_sticky/clr_ovf/done/op_count (status).
module alu_writeback
   import alu_wb_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*VEC_W-1:0]   result,
   input  logic [2*LANES-1:0]   cc,
   input  logic [REG_IDX_W-1:0] rd_lo,
   input  logic [REG_IDX_W-1:0] rd_hi,
   input  logic                 wr_hi,
   input  logic                 wr_stall,
   output logic                 wr_en,
   output logic [REG_IDX_W-1:0] wr_addr,
   output logic [VEC_W-1:0]     wr_data,
   output logic [2*LANES-1:0]   cc_q,
   output logic                 ovf_sticky,
   input  logic                 clr_ovf,
   output logic                 done,
   output logic [15:0]          op_count
);

   wb_state_t              state_q, state_d;
   logic [2*VEC_W-1:0]     result_q;
   logic [REG_IDX_W-1:0]   rd_lo_q, rd_hi_q;
   logic                   wr_hi_q;
   logic                   capture;
   logic                   last_commit;
   logic                   any_ovf;

   assign capture = in_valid && in_ready;

   lane_ovf_reduce u_ovf (
      .cc      (cc),
      .any_ovf (any_ovf)
   );

   // Write outputs are decoded from the state and captured registers only, so a
   // stall holds them naturally by holding the state.
   always_comb begin
      state_d     = state_q;
      in_ready    = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      last_commit = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = WR_LO;
            end
         end
         WR_LO: begin
            wr_en   = 1'b1;
            wr_addr = rd_lo_q;
            wr_data = result_q[VEC_W-1:0];
            if (!wr_stall) begin
               if (wr_hi_q) begin
                  state_d = WR_HI;
               end else begin
                  state_d     = IDLE;
                  last_commit = 1'b1;
               end
            end
         end
         WR_HI: begin
            wr_en   = 1'b1;
            wr_addr = rd_hi_q;
            wr_data = result_q[2*VEC_W-1:VEC_W];
            if (!wr_stall) begin
               state_d     = IDLE;
               last_commit = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         result_q   <= '0;
         rd_lo_q    <= '0;
         rd_hi_q    <= '0;
         wr_hi_q    <= 1'b0;
         cc_q       <= '0;
         ovf_sticky <= 1'b0;
         done       <= 1'b0;
         op_count   <= '0;
      end else begin
         state_q <= state_d;
         done    <= last_commit;
         if (capture) begin
            result_q <= result;
            rd_lo_q  <= rd_lo;
            rd_hi_q  <= rd_hi;
            wr_hi_q  <= wr_hi;
            cc_q     <= cc;
         end
         // A capture that reports overflow beats a simultaneous clear.
         if (capture && any_ovf) begin
            ovf_sticky <= 1'b1;
         end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
         end
         if (last_commit && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;
   import alu_wb_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [1023:0] result;
   logic [31:0]   cc;
   logic [1:0]    rd_lo, rd_hi;
   logic          wr_hi;
   logic          wr_stall;
   logic          wr_en;
   logic [1:0]    wr_addr;
   logic [511:0]  wr_data;
   logic [31:0]   cc_q;
   logic          ovf_sticky;
   logic          clr_ovf;
   logic          done;
   logic [15:0]   op_count;

   alu_writeback dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .result     (result),
      .cc         (cc),
      .rd_lo      (rd_lo),
      .rd_hi      (rd_hi),
      .wr_hi      (wr_hi),
      .wr_stall   (wr_stall),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cc_q       (cc_q),
      .ovf_sticky (ovf_sticky),
      .clr_ovf    (clr_ovf),
      .done       (done),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference state: what the stage should report after each operation.
   logic [15:0] m_cnt;
   logic        m_sticky;
   logic [31:0] m_cc;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic lane_has_ovf(input logic [31:0] c);
      for (int i = 0; i < 16; i++) begin
         if (c[2*i +: 2] == 2'b11) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic [1023:0] rand1024();
      logic [1023:0] v;
      for (int i = 0; i < 32; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   // One full operation. mode 0: no stall, 1: random stalls, 2: three stalls on the high write.
   task automatic do_op(input logic [1023:0] res, input logic [31:0] c,
                        input logic [1:0] lo, input logic [1:0] hi,
                        input logic whi, input logic clr, input int mode);
      logic [1:0]   exp_addr [2];
      logic [511:0] exp_dat  [2];
      int           nw;
      int           stalls;
      logic         s;
      chk("idle_in_ready", in_ready, 1);
      chk("idle_wr_en", wr_en, 0);
      chk("idle_wr_addr", wr_addr, 0);
      chk("idle_wr_data", wr_data, 0);
      in_valid = 1'b1; result = res; cc = c;
      rd_lo = lo; rd_hi = hi; wr_hi = whi; clr_ovf = clr;
      @(posedge clk);
      m_cc = c;
      if (lane_has_ovf(c)) m_sticky = 1'b1;
      else if (clr)        m_sticky = 1'b0;
      @(negedge clk);
      // Scramble the inputs so the writes must come from captured copies.
      in_valid = 1'b0; clr_ovf = 1'b0;
      result = rand1024(); cc = $urandom; rd_lo = ~lo; rd_hi = ~hi; wr_hi = ~whi;
      exp_addr[0] = lo; exp_dat[0] = res[511:0];
      exp_addr[1] = hi; exp_dat[1] = res[1023:512];
      nw = whi ? 2 : 1;
      for (int w = 0; w < nw; w++) begin
         stalls = 0;
         for (int k = 0; k < 8; k++) begin
            chk("wr_en", wr_en, 1);
            chk("wr_addr", wr_addr, exp_addr[w]);
            chk("wr_data", wr_data, exp_dat[w]);
            chk("busy_in_ready", in_ready, 0);
            chk("busy_done", done, 0);
            if (mode == 1)      s = (stalls < 3) && ($urandom_range(0, 2) == 0);
            else if (mode == 2) s = (w == 1) && (stalls < 3);
            else                s = 1'b0;
            wr_stall = s;
            if (s) stalls++;
            @(posedge clk);
            @(negedge clk);
            if (!s) break;
         end
         if (mode == 2 && w == 1) chk("stall_cycles", stalls, 3);
      end
      wr_stall = 1'b0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      chk("done_pulse", done, 1);
      chk("op_count", op_count, m_cnt);
      chk("ovf_sticky", ovf_sticky, m_sticky);
      chk("cc_q", cc_q, m_cc);
      chk("end_in_ready", in_ready, 1);
      chk("end_wr_en", wr_en, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      logic [1023:0] r;
      rst = 1'b1; in_valid = 1'b0; result = '0; cc = '0; rd_lo = '0; rd_hi = '0;
      wr_hi = 1'b0; wr_stall = 1'b0; clr_ovf = 1'b0;
      m_cnt = '0; m_sticky = 1'b0; m_cc = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_cc_q", cc_q, 0);
      chk("rst_ovf_sticky", ovf_sticky, 0);
      chk("rst_done", done, 0);
      chk("rst_op_count", op_count, 0);

      // Add: lanes hold 5, single low write to register 1.
      r = rand1024();
      for (int i = 0; i < 16; i++) r[32*i +: 32] = 32'd5;
      do_op(r, 32'hAAAA_AAAA, 2'd1, 2'd0, 1'b0, 1'b0, 0);
      chk("add_sticky", ovf_sticky, 0);

      // Multiply: lane 7 overflows, writes to 2 then 3.
      do_op(rand1024(), 32'hAAAA_EAAA, 2'd2, 2'd3, 1'b1, 1'b0, 0);
      chk("mul_sticky", ovf_sticky, 1);
      chk("mul_cc_lane7", cc_q[15:14], 2'b11);

      // Three-cycle stall on the high write.
      do_op(rand1024(), 32'h5555_5555, 2'd0, 2'd1, 1'b1, 1'b0, 2);

      // Clear coinciding with an overflowing capture, same register for both halves.
      do_op(rand1024(), 32'h0000_0003, 2'd1, 2'd1, 1'b1, 1'b1, 0);
      chk("clr_vs_set", ovf_sticky, 1);
      clr_ovf = 1'b1;
      @(posedge clk);
      m_sticky = 1'b0;
      @(negedge clk);
      clr_ovf = 1'b0;
      chk("clr_alone", ovf_sticky, 0);

      // Randomized operations.
      repeat (24) begin
         do_op(rand1024(), $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1);
      end

      // Reset while the low write is pending.
      in_valid = 1'b1; result = rand1024(); cc = 32'hC000_0000;
      rd_lo = 2'd3; rd_hi = 2'd2; wr_hi = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_wr_en", wr_en, 1);
      rst = 1'b1;
      #1;
      chk("midrst_wr_en", wr_en, 0);
      chk("midrst_wr_data", wr_data, 0);
      chk("midrst_op_count", op_count, 0);
      chk("midrst_sticky", ovf_sticky, 0);
      chk("midrst_cc_q", cc_q, 0);
      @(posedge clk);
      @(negedge clk);
      chk("midrst_done", done, 0);
      rst = 1'b0;
      m_cnt = '0; m_sticky = 1'b0; m_cc = '0;
      @(negedge clk);
      chk("postrst_done", done, 0);
      chk("postrst_wr_en", wr_en, 0);
      do_op(rand1024(), $urandom, 2'd2, 2'd0, 1'b0, 1'b0, 0);

      // Saturation: preload the count just below the limit.
      @(negedge clk);
      force dut.op_count = 16'hFFFE;
      @(posedge clk);
      @(negedge clk);
      release dut.op_count;
      m_cnt = 16'hFFFE;
      @(negedge clk);
      chk("preload", op_count, 16'hFFFE);
      do_op(rand1024(), $urandom, 2'd1, 2'd2, 1'b1, 1'b0, 0);
      do_op(rand1024(), $urandom, 2'd0, 2'd3, 1'b0, 1'b0, 0);
      do_op(rand1024(), $urandom, 2'd3, 2'd3, 1'b1, 1'b0, 1);
      chk("saturated", op_count, 16'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
